// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite types and constants for the two-requester arbiter.
// Holds response codes, channel FSM state encodings and bus widths.
package axi_lite_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [DATA_W-1:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    W_IDLE,
    W_XFER,
    W_RESP,
    W_ERR
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA,
    R_ERR
  } rd_state_t;

  // Index of the requester named by a one-hot two-bit grant.
  function automatic logic grant_idx(input logic [1:0] grant);
    return grant[1];
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: combinational grant, registered tie-break
// pointer that moves away from the requester just served on each update.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       served,
  output logic [1:0] grant
);

  // Requester that wins when both ask in the same cycle.
  logic prio_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_reg <= 1'b0;
    end else if (update) begin
      prio_reg <= ~served;
    end
  end

  always_comb begin
    grant = req;
    if (req[0] && req[1]) begin
      grant           = 2'b00;
      grant[prio_reg] = 1'b1;
    end
  end

endmodule

// File: rtl/axi_lite_arbiter.sv
// Shares one AXI-Lite master port between the CPU (s0) and the Ethernet DMA (s1).
// Write and read channels arbitrate independently; each has its own watchdog.
module axi_lite_arbiter
  import axi_lite_pkg::*;
#(
  parameter int unsigned       TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_W-1:0] ERR_RDATA      = DEFAULT_ERR_RDATA
) (
  input  logic              clk,
  input  logic              rst_n,
  // requester 0 (CPU)
  input  logic [ADDR_W-1:0] s0_awaddr,
  input  logic              s0_awvalid,
  output logic              s0_awready,
  input  logic [DATA_W-1:0] s0_wdata,
  input  logic [STRB_W-1:0] s0_wstrb,
  input  logic              s0_wlast,
  input  logic              s0_wvalid,
  output logic              s0_wready,
  output logic [1:0]        s0_bresp,
  output logic              s0_bvalid,
  input  logic              s0_bready,
  input  logic [ADDR_W-1:0] s0_araddr,
  input  logic              s0_arvalid,
  output logic              s0_arready,
  output logic [DATA_W-1:0] s0_rdata,
  output logic [1:0]        s0_rresp,
  output logic              s0_rlast,
  output logic              s0_rvalid,
  input  logic              s0_rready,
  // requester 1 (Ethernet DMA)
  input  logic [ADDR_W-1:0] s1_awaddr,
  input  logic              s1_awvalid,
  output logic              s1_awready,
  input  logic [DATA_W-1:0] s1_wdata,
  input  logic [STRB_W-1:0] s1_wstrb,
  input  logic              s1_wlast,
  input  logic              s1_wvalid,
  output logic              s1_wready,
  output logic [1:0]        s1_bresp,
  output logic              s1_bvalid,
  input  logic              s1_bready,
  input  logic [ADDR_W-1:0] s1_araddr,
  input  logic              s1_arvalid,
  output logic              s1_arready,
  output logic [DATA_W-1:0] s1_rdata,
  output logic [1:0]        s1_rresp,
  output logic              s1_rlast,
  output logic              s1_rvalid,
  input  logic              s1_rready,
  // master port to the interconnect
  output logic [ADDR_W-1:0] m_awaddr,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [DATA_W-1:0] m_wdata,
  output logic [STRB_W-1:0] m_wstrb,
  output logic              m_wlast,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic              wr_timeout,
  output logic              rd_timeout
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic WDOG_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // Requester buses gathered into arrays so routing is index-driven.
  logic [1:0]        s_awvalid, s_wvalid, s_wlast, s_bready, s_arvalid, s_rready;
  logic [ADDR_W-1:0] s_awaddr [2];
  logic [ADDR_W-1:0] s_araddr [2];
  logic [DATA_W-1:0] s_wdata  [2];
  logic [STRB_W-1:0] s_wstrb  [2];
  logic [1:0]        s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rlast;
  logic [1:0]        s_bresp  [2];
  logic [1:0]        s_rresp  [2];
  logic [DATA_W-1:0] s_rdata  [2];

  assign s_awvalid   = {s1_awvalid, s0_awvalid};
  assign s_wvalid    = {s1_wvalid, s0_wvalid};
  assign s_wlast     = {s1_wlast, s0_wlast};
  assign s_bready    = {s1_bready, s0_bready};
  assign s_arvalid   = {s1_arvalid, s0_arvalid};
  assign s_rready    = {s1_rready, s0_rready};
  assign s_awaddr[0] = s0_awaddr;
  assign s_awaddr[1] = s1_awaddr;
  assign s_araddr[0] = s0_araddr;
  assign s_araddr[1] = s1_araddr;
  assign s_wdata[0]  = s0_wdata;
  assign s_wdata[1]  = s1_wdata;
  assign s_wstrb[0]  = s0_wstrb;
  assign s_wstrb[1]  = s1_wstrb;

  assign s0_awready = s_awready[0];
  assign s1_awready = s_awready[1];
  assign s0_wready  = s_wready[0];
  assign s1_wready  = s_wready[1];
  assign s0_bvalid  = s_bvalid[0];
  assign s1_bvalid  = s_bvalid[1];
  assign s0_bresp   = s_bresp[0];
  assign s1_bresp   = s_bresp[1];
  assign s0_arready = s_arready[0];
  assign s1_arready = s_arready[1];
  assign s0_rvalid  = s_rvalid[0];
  assign s1_rvalid  = s_rvalid[1];
  assign s0_rdata   = s_rdata[0];
  assign s1_rdata   = s_rdata[1];
  assign s0_rresp   = s_rresp[0];
  assign s1_rresp   = s_rresp[1];
  assign s0_rlast   = s_rlast[0];
  assign s1_rlast   = s_rlast[1];

  // ---------------- write channel state ----------------
  wr_state_t         w_state_reg;
  logic              w_sel_reg;
  logic [ADDR_W-1:0] awaddr_reg;
  logic              aw_done_reg, w_done_reg;
  logic [CNT_W-1:0]  w_cnt_reg, w_cnt_next;
  logic              wr_timeout_reg;
  logic              w_in_xfer, w_in_resp, w_in_err;
  logic [1:0]        w_req, w_grant;
  logic              aw_acc, w_acc, b_done, w_update, w_expired;

  assign w_in_xfer = (w_state_reg == W_XFER);
  assign w_in_resp = (w_state_reg == W_RESP);
  assign w_in_err  = (w_state_reg == W_ERR);
  assign w_req     = (w_state_reg == W_IDLE) ? s_awvalid : 2'b00;

  assign aw_acc    = s_awvalid[w_sel_reg] & s_awready[w_sel_reg];
  assign w_acc     = s_wvalid[w_sel_reg] & s_wready[w_sel_reg];
  assign b_done    = s_bvalid[w_sel_reg] & s_bready[w_sel_reg];
  assign w_update  = (w_in_resp | w_in_err) & b_done;
  assign w_expired = WDOG_EN & (w_cnt_reg == CNT_LAST);
  assign w_cnt_next = (&w_cnt_reg) ? w_cnt_reg : w_cnt_reg + 1'b1;

  rr_arb2 u_wr_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (w_req),
    .update (w_update),
    .served (w_sel_reg),
    .grant  (w_grant)
  );

  // ---------------- read channel state ----------------
  rd_state_t         r_state_reg;
  logic              r_sel_reg;
  logic [ADDR_W-1:0] araddr_reg;
  logic              ar_pend_reg;
  logic [CNT_W-1:0]  r_cnt_reg, r_cnt_next;
  logic              rd_timeout_reg;
  logic              r_in_addr, r_in_data, r_in_err;
  logic [1:0]        r_req, r_grant;
  logic              ar_acc, r_done, r_update, r_expired;

  assign r_in_addr = (r_state_reg == R_ADDR);
  assign r_in_data = (r_state_reg == R_DATA);
  assign r_in_err  = (r_state_reg == R_ERR);
  assign r_req     = (r_state_reg == R_IDLE) ? s_arvalid : 2'b00;

  assign ar_acc    = s_arvalid[r_sel_reg] & s_arready[r_sel_reg];
  assign r_done    = s_rvalid[r_sel_reg] & s_rready[r_sel_reg];
  assign r_update  = (r_in_data | r_in_err) & r_done;
  assign r_expired = WDOG_EN & (r_cnt_reg == CNT_LAST);
  assign r_cnt_next = (&r_cnt_reg) ? r_cnt_reg : r_cnt_reg + 1'b1;

  rr_arb2 u_rd_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (r_req),
    .update (r_update),
    .served (r_sel_reg),
    .grant  (r_grant)
  );

  // ---------------- master-side drive ----------------
  assign m_awaddr  = awaddr_reg;
  assign m_awvalid = w_in_xfer & s_awvalid[w_sel_reg] & ~aw_done_reg;
  assign m_wvalid  = w_in_xfer & s_wvalid[w_sel_reg] & ~w_done_reg;
  assign m_wdata   = s_wdata[w_sel_reg];
  assign m_wstrb   = s_wstrb[w_sel_reg];
  assign m_wlast   = s_wlast[w_sel_reg];
  assign m_bready  = w_in_resp & s_bready[w_sel_reg];
  assign m_araddr  = araddr_reg;
  assign m_arvalid = r_in_addr & s_arvalid[r_sel_reg];
  assign m_rready  = r_in_data & s_rready[r_sel_reg];

  assign wr_timeout = wr_timeout_reg;
  assign rd_timeout = rd_timeout_reg;

  // ---------------- requester-side routing ----------------
  // Only the owner of a channel sees anything; the other requester sees zeros.
  for (genvar gi = 0; gi < 2; gi++) begin : g_route
    localparam logic ID = 1'(gi);
    logic w_own, r_own;

    assign w_own = (w_sel_reg == ID);
    assign r_own = (r_sel_reg == ID);

    assign s_awready[gi] = w_own & ~aw_done_reg & ((w_in_xfer & m_awready) | w_in_err);
    assign s_wready[gi]  = w_own & ~w_done_reg & ((w_in_xfer & m_wready) | w_in_err);
    assign s_bvalid[gi]  = w_own & ((w_in_resp & m_bvalid) | w_in_err);
    assign s_bresp[gi]   = !w_own   ? RESP_OKAY :
                           w_in_err ? RESP_SLVERR :
                           w_in_resp ? m_bresp : RESP_OKAY;

    assign s_arready[gi] = r_own & ((r_in_addr & m_arready) | (r_in_err & ar_pend_reg));
    assign s_rvalid[gi]  = r_own & ((r_in_data & m_rvalid) | r_in_err);
    assign s_rdata[gi]   = !r_own    ? '0 :
                           r_in_err  ? ERR_RDATA :
                           r_in_data ? m_rdata : '0;
    assign s_rresp[gi]   = !r_own    ? RESP_OKAY :
                           r_in_err  ? RESP_SLVERR :
                           r_in_data ? m_rresp : RESP_OKAY;
    assign s_rlast[gi]   = r_own & (r_in_err | (r_in_data & m_rlast));
  end

  // ---------------- write FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_reg    <= W_IDLE;
      w_sel_reg      <= 1'b0;
      awaddr_reg     <= '0;
      aw_done_reg    <= 1'b0;
      w_done_reg     <= 1'b0;
      w_cnt_reg      <= '0;
      wr_timeout_reg <= 1'b0;
    end else begin
      wr_timeout_reg <= 1'b0;
      case (w_state_reg)
        W_IDLE: begin
          if (|w_grant) begin
            w_state_reg <= W_XFER;
            w_sel_reg   <= grant_idx(w_grant);
            awaddr_reg  <= s_awaddr[grant_idx(w_grant)];
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            w_cnt_reg   <= '0;
          end
        end
        W_XFER: begin
          aw_done_reg <= aw_done_reg | aw_acc;
          w_done_reg  <= w_done_reg | w_acc;
          // Completion wins over a timeout landing on the same edge.
          if ((aw_done_reg | aw_acc) && (w_done_reg | w_acc)) begin
            w_state_reg <= W_RESP;
            w_cnt_reg   <= '0;
          end else if (w_expired) begin
            w_state_reg    <= W_ERR;
            w_cnt_reg      <= '0;
            wr_timeout_reg <= 1'b1;
          end else begin
            w_cnt_reg <= w_cnt_next;
          end
        end
        W_RESP: begin
          if (b_done) begin
            w_state_reg <= W_IDLE;
            w_cnt_reg   <= '0;
          end else if (w_expired) begin
            w_state_reg    <= W_ERR;
            w_cnt_reg      <= '0;
            wr_timeout_reg <= 1'b1;
          end else begin
            w_cnt_reg <= w_cnt_next;
          end
        end
        W_ERR: begin
          aw_done_reg <= aw_done_reg | aw_acc;
          w_done_reg  <= w_done_reg | w_acc;
          if (b_done) begin
            w_state_reg <= W_IDLE;
            w_cnt_reg   <= '0;
          end
        end
        default: w_state_reg <= W_IDLE;
      endcase
    end
  end

  // ---------------- read FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_reg    <= R_IDLE;
      r_sel_reg      <= 1'b0;
      araddr_reg     <= '0;
      ar_pend_reg    <= 1'b0;
      r_cnt_reg      <= '0;
      rd_timeout_reg <= 1'b0;
    end else begin
      rd_timeout_reg <= 1'b0;
      case (r_state_reg)
        R_IDLE: begin
          if (|r_grant) begin
            r_state_reg <= R_ADDR;
            r_sel_reg   <= grant_idx(r_grant);
            araddr_reg  <= s_araddr[grant_idx(r_grant)];
            ar_pend_reg <= 1'b0;
            r_cnt_reg   <= '0;
          end
        end
        R_ADDR: begin
          if (ar_acc) begin
            r_state_reg <= R_DATA;
            r_cnt_reg   <= '0;
          end else if (r_expired) begin
            // AR was never taken downstream; soak it up in the error state.
            r_state_reg    <= R_ERR;
            ar_pend_reg    <= 1'b1;
            r_cnt_reg      <= '0;
            rd_timeout_reg <= 1'b1;
          end else begin
            r_cnt_reg <= r_cnt_next;
          end
        end
        R_DATA: begin
          if (r_done) begin
            r_state_reg <= R_IDLE;
            r_cnt_reg   <= '0;
          end else if (r_expired) begin
            r_state_reg    <= R_ERR;
            ar_pend_reg    <= 1'b0;
            r_cnt_reg      <= '0;
            rd_timeout_reg <= 1'b1;
          end else begin
            r_cnt_reg <= r_cnt_next;
          end
        end
        R_ERR: begin
          if (ar_acc) begin
            ar_pend_reg <= 1'b0;
          end
          if (r_done) begin
            r_state_reg <= R_IDLE;
            r_cnt_reg   <= '0;
          end
        end
        default: r_state_reg <= R_IDLE;
      endcase
    end
  end

endmodule
